// File: rtl/div_seq_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    // Default operand width and iteration counter width (counter must hold WIDTH).
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    // Field split of the packed result z = {remainder, quotient}.
    localparam int REM_HI = 2*DEF_WIDTH-1;
    localparam int REM_LO = DEF_WIDTH;
    localparam int QUO_HI = DEF_WIDTH-1;
    localparam int QUO_LO = 0;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the core and the divider.
//
// Handshake: start is a request that is taken only when busy==0 (controller
// idle); a start seen while busy is dropped. sign/a/b must be valid in the
// cycle start is taken. done is a one-cycle pulse marking z/dbz valid; they
// then hold until the next result or reset. dbg_state mirrors the controller
// state for observation only.
interface div_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic               start;
    logic               sign;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] z;
    logic               busy;
    logic               done;
    logic               dbz;
    state_t             dbg_state;

    modport master (
        output start, sign, a, b,
        input  z, busy, done, dbz, dbg_state
    );

    modport slave (
        input  start, sign, a, b,
        output z, busy, done, dbz, dbg_state
    );
endinterface

// File: rtl/div_seq_step.sv
// One restoring radix-2 division step: shift {rem,quo} left, trial-subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    // One extra bit on the shifted remainder so the borrow of the trial
    // subtraction lands in diff[WIDTH] instead of being lost.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Trial subtraction; keep the difference only if it did not borrow.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            // Borrow means rem_sh < divisor < 2^WIDTH, so the top bit is zero.
            rem_nxt = rem_sh[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Iterative signed/unsigned divider for DIV/DIVU: one quotient bit per clock,
// result packed as z = {remainder, quotient} to feed HI/LO.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      reset,
    div_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH-1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   a_cap;
    logic [WIDTH-1:0]   b_cap;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] z_r;
    logic               dbz_r;
    logic               done_r;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_nxt (rem_step),
        .quo_nxt (quo_step)
    );

    // Operand magnitudes (two's-complement negate only for signed negatives;
    // 0x80..0 stays 0x80..0, read as unsigned) and sign-corrected results.
    always_comb begin
        a_mag   = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag   = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        rem_fix = neg_r ? -rem : rem;
        quo_fix = neg_q ? -quo : quo;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == LAST_STEP) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state plus the registered result.
    always_comb begin
        bus.busy      = (state == CALC) || (state == FIX);
        bus.dbg_state = state;
        bus.z         = z_r;
        bus.dbz       = dbz_r;
        bus.done      = done_r;
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            a_cap  <= '0;
            b_cap  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            z_r    <= '0;
            dbz_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        a_cap <= bus.a;
                        b_cap <= bus.b;
                        neg_q <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r <= bus.sign & bus.a[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // Divide by zero: pin the result so it does not depend on sign.
                    if (b_cap == '0) begin
                        z_r   <= {a_cap, {WIDTH{1'b1}}};
                        dbz_r <= 1'b1;
                    end else begin
                        z_r   <= {rem_fix, quo_fix};
                        dbz_r <= 1'b0;
                    end
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Randomised and directed bench for div_seq with a queue-based scoreboard.
module tb_div_seq;
    import div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;

    logic [2*W:0]   exp_q[$];
    int             acc_q[$];
    logic [2*W-1:0] last_z;

    div_seq_if #(.WIDTH(W)) bus_if ();

    div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Clock and edge counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: language-level division rules.
    function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
        int sa;
        int sb;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end
        return {1'b0, r, q};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && bus_if.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                logic [2*W:0] e;
                int acc;
                e = exp_q.pop_front();
                acc = acc_q.pop_front();
                chk("z", bus_if.z, e[2*W-1:0]);
                chk("dbz", bus_if.dbz, e[2*W]);
                chk("busy_at_done", bus_if.busy, 1'b0);
                chk("latency", cyc - acc, LAT);
                last_z = e[2*W-1:0];
            end
        end
    end

    task automatic issue(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W:0] e);
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        bus_if.sign  = s;
        bus_if.a     = ia;
        bus_if.b     = ib;
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 1'b0, 1'b1);
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic rand_op();
        logic s;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        s  = 1'($urandom_range(0, 1));
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = W'($urandom_range(1, 20));
            3: ra = 32'h8000_0000;
            4: rb = rb >> $urandom_range(0, 31);
            default: ;
        endcase
        issue(s, ra, rb, model(s, ra, rb));
        wait_drain();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_z = '0;
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.sign  = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("reset_z", bus_if.z, '0);
        chk("reset_busy", bus_if.busy, 1'b0);
        chk("reset_done", bus_if.done, 1'b0);
        chk("reset_dbz", bus_if.dbz, 1'b0);
        chk("reset_state", bus_if.dbg_state, IDLE);

        // Directed cases with hand-derived results.
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0100, {1'b0, 64'h0000_00FF_00FF_FFFF}); wait_drain();
        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD}); wait_drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0100, {1'b0, 64'hFFFF_FFFF_0000_0000}); wait_drain();
        issue(1'b0, 32'd100, 32'd0, {1'b1, 64'h0000_0064_FFFF_FFFF}); wait_drain();
        issue(1'b1, 32'd100, 32'd0, {1'b1, 64'h0000_0064_FFFF_FFFF}); wait_drain();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 64'h0000_0000_8000_0000}); wait_drain();

        // Start pulses during an operation are dropped; z holds the old result.
        issue(1'b0, 32'd1000, 32'd7, {1'b0, 32'd6, 32'd142});
        repeat (3) @(posedge clk);
        #1 bus_if.start = 1'b1; bus_if.a = 32'd55; bus_if.b = 32'd5;
        @(posedge clk); #1 bus_if.start = 1'b0;
        chk("z_hold_c5", bus_if.z, last_z);
        repeat (14) @(posedge clk);
        #1 bus_if.start = 1'b1; bus_if.a = 32'd77; bus_if.b = 32'd3;
        @(posedge clk); #1 bus_if.start = 1'b0;
        chk("z_hold_c20", bus_if.z, last_z);
        wait_drain();
        repeat (40) @(posedge clk);

        // Start held through done: second op accepted right after the first done.
        begin
            int n;
            logic seen;
            @(posedge clk); #1;
            bus_if.start = 1'b1; bus_if.sign = 1'b0; bus_if.a = 32'd500; bus_if.b = 32'd9;
            exp_q.push_back(model(1'b0, 32'd500, 32'd9));
            acc_q.push_back(cyc + 1);
            n = 0;
            seen = 1'b0;
            while (!seen && n < 60) begin
                @(negedge clk);
                n++;
                if (bus_if.done) seen = 1'b1;
            end
            if (seen) begin
                exp_q.push_back(model(1'b0, 32'd500, 32'd9));
                acc_q.push_back(cyc + 1);
            end else begin
                chk("b2b_first_done", 1'b0, 1'b1);
            end
            @(posedge clk); #1 bus_if.start = 1'b0;
            wait_drain();
        end

        // Reset during CALC discards the operation with no done pulse.
        issue(1'b0, 32'd12345, 32'd11, {1'b0, 64'd0});
        repeat (8) @(posedge clk);
        exp_q.delete();
        acc_q.delete();
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midreset_busy", bus_if.busy, 1'b0);
        chk("midreset_z", bus_if.z, '0);
        chk("midreset_done", bus_if.done, 1'b0);
        repeat (40) @(posedge clk);
        issue(1'b0, 32'd100, 32'd7, {1'b0, 64'h0000_0002_0000_000E}); wait_drain();

        // Random operations against the model.
        for (int i = 0; i < 40; i++) rand_op();

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
